// File: rtl/regfile_mult_ctrl_if.sv
// Signal bundle between the multiplier controller and its register file / requester.
// master is the controller's view, slave is the environment's view.
interface regfile_mult_ctrl_if #(
  parameter int N = 4
);
  logic           start;
  logic           mode;
  logic [N-1:0]   x;
  logic [N-1:0]   y;
  logic [N-1:0]   a_bus;
  logic [N-1:0]   b_bus;
  logic [N-1:0]   rf_d;
  logic           rf_da;
  logic           rf_w;
  logic           rf_sa;
  logic           rf_sb;
  logic           rf_rst;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;

  modport master (
    input  start, mode, x, y, a_bus, b_bus,
    output rf_d, rf_da, rf_w, rf_sa, rf_sb, rf_rst, product, busy, done
  );

  modport slave (
    output start, mode, x, y, a_bus, b_bus,
    input  rf_d, rf_da, rf_w, rf_sa, rf_sb, rf_rst, product, busy, done
  );
endinterface

// File: rtl/regfile_mult_ctrl.sv
// Moore controller: loads X/Y into a two-entry register file, reads both entries
// back onto the A/B buses and registers their full-width unsigned product.
module regfile_mult_ctrl #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_mult_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD0 = 3'd1,
    LOAD1 = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [N-1:0]   x_q;
  logic [N-1:0]   y_q;
  logic           mode_q;
  logic [2*N-1:0] product_q;
  logic [2*N-1:0] mult_full;

  // Zero-extend before multiplying so the product keeps all 2N bits.
  assign mult_full = {{N{1'b0}}, bus.a_bus} * {{N{1'b0}}, bus.b_bus};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      mode_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start) begin
        x_q    <= bus.x;
        y_q    <= bus.y;
        mode_q <= bus.mode;
      end
      if (state_q == READ) begin
        product_q <= mult_full;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bus.rf_w  = 1'b0;
    bus.rf_da = 1'b0;
    bus.rf_sa = 1'b0;
    bus.rf_sb = 1'b0;
    bus.rf_d  = '0;
    bus.done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = LOAD0;
      end
      LOAD0: begin
        bus.rf_w  = 1'b1;
        bus.rf_da = 1'b0;
        bus.rf_d  = x_q;
        state_d   = mode_q ? READ : LOAD1;
      end
      LOAD1: begin
        bus.rf_w  = 1'b1;
        bus.rf_da = 1'b1;
        bus.rf_d  = y_q;
        state_d   = READ;
      end
      READ: begin
        // Square mode reads R00 on both buses.
        bus.rf_sa = 1'b0;
        bus.rf_sb = ~mode_q;
        state_d   = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.product = product_q;
  assign bus.rf_rst  = ~rst;

endmodule

// File: tb/tb_regfile_mult_ctrl.sv
// Bench for regfile_mult_ctrl: models the two-entry register file, checks control
// decode per cycle and scores every done pulse against a queue of expected products.
module tb_regfile_mult_ctrl;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   done_cnt;
  logic wr_da1_seen;
  logic [2*N-1:0] sb_q[$];
  logic [N-1:0]   rf_mem[2];

  regfile_mult_ctrl_if #(.N(N)) bus ();

  regfile_mult_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge bus.rf_rst) begin
    if (bus.rf_rst) begin
      rf_mem[0] <= '0;
      rf_mem[1] <= '0;
    end else if (bus.rf_w) begin
      rf_mem[bus.rf_da] <= bus.rf_d;
    end
  end

  assign bus.a_bus = rf_mem[bus.rf_sa];
  assign bus.b_bus = rf_mem[bus.rf_sb];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && bus.rf_w && bus.rf_da) wr_da1_seen = 1'b1;
    if (rst && bus.done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("product", 32'(bus.product), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic m, input logic [N-1:0] xv, input logic [N-1:0] yv,
                       input logic [2*N-1:0] exp);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.x     = xv;
    bus.y     = yv;
    sb_q.push_back(exp);
  endtask

  int d0;

  initial begin
    total = 0; bad = 0; done_cnt = 0; wr_da1_seen = 1'b0;
    rst = 1'b0;
    bus.start = 1'($urandom); bus.mode = 1'($urandom);
    bus.x = 4'($urandom); bus.y = 4'($urandom);

    // Reset with random inputs
    repeat (3) begin
      cyc();
      bus.start = 1'($urandom); bus.x = 4'($urandom); bus.y = 4'($urandom);
    end
    chk("rst_product", 32'(bus.product), 32'h00);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    chk("rst_rf_w",    32'(bus.rf_w),    32'd0);
    chk("rst_rf_rst",  32'(bus.rf_rst),  32'd1);
    bus.start = 1'b0;
    rst = 1'b1;
    cyc(3);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_rf_rst", 32'(bus.rf_rst), 32'd0);

    // Multiply 3x5
    issue(1'b0, 4'd3, 4'd5, 8'h0F);
    cyc();
    bus.start = 1'b0; bus.x = 4'hA; bus.y = 4'hA;
    chk("mul_c1", {bus.rf_w, bus.rf_da, 2'b0, bus.rf_d}, {1'b1, 1'b0, 2'b0, 4'd3});
    cyc();
    chk("mul_c2", {bus.rf_w, bus.rf_da, 2'b0, bus.rf_d}, {1'b1, 1'b1, 2'b0, 4'd5});
    cyc();
    chk("mul_c3", {bus.rf_w, bus.rf_sa, bus.rf_sb}, 3'b001);
    cyc();
    chk("mul_c4_done", 32'(bus.done), 32'd1);
    cyc();
    chk("mul_c5_done", 32'(bus.done), 32'd0);
    chk("mul_c5_busy", 32'(bus.busy), 32'd0);

    // Full range 15x15 then back-to-back 0x9 with start held high
    issue(1'b0, 4'd15, 4'd15, 8'hE1);
    cyc();
    bus.x = 4'd0; bus.y = 4'd9;
    cyc(3);
    chk("b2b_done_cycle", 32'(bus.done), 32'd1);
    cyc();
    chk("b2b_idle_c5", 32'(bus.busy), 32'd0);
    sb_q.push_back(8'h00);
    cyc();
    bus.start = 1'b0;
    chk("b2b_accept_c6", {bus.busy, bus.rf_w, bus.rf_da}, 3'b110);
    cyc(5);
    chk("b2b_product", 32'(bus.product), 32'h00);

    // Square 7x7
    wr_da1_seen = 1'b0;
    issue(1'b1, 4'd7, 4'd2, 8'h31);
    cyc();
    bus.start = 1'b0;
    chk("sq_c1", {bus.rf_w, bus.rf_da, 2'b0, bus.rf_d}, {1'b1, 1'b0, 2'b0, 4'd7});
    cyc();
    chk("sq_c2_read", {bus.rf_w, bus.rf_sa, bus.rf_sb}, 3'b000);
    cyc();
    chk("sq_c3_done", 32'(bus.done), 32'd1);
    cyc(2);
    chk("sq_no_da1_write", 32'(wr_da1_seen), 32'd0);

    // Busy ignore: second start during LOAD1 is discarded
    d0 = done_cnt;
    issue(1'b0, 4'd2, 4'd6, 8'h0C);
    cyc();
    bus.start = 1'b0;
    cyc();
    bus.start = 1'b1; bus.x = 4'd9;
    cyc();
    bus.start = 1'b0;
    cyc(8);
    chk("ignore_done_count", 32'(done_cnt - d0), 32'd1);
    chk("ignore_product", 32'(bus.product), 32'h0C);

    // Reset mid-operation during LOAD1
    d0 = done_cnt;
    issue(1'b0, 4'd4, 4'd4, 8'h10);
    cyc();
    bus.start = 1'b0;
    cyc();
    #2 rst = 1'b0;
    #1;
    sb_q.delete();
    chk("midrst_busy",    32'(bus.busy),    32'd0);
    chk("midrst_product", 32'(bus.product), 32'h00);
    chk("midrst_rf_rst",  32'(bus.rf_rst),  32'd1);
    cyc(2);
    rst = 1'b1;
    cyc(4);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    issue(1'b0, 4'd2, 4'd3, 8'h06);
    cyc();
    bus.start = 1'b0;
    cyc(6);
    chk("post_rst_product", 32'(bus.product), 32'h06);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
